// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size codes, FSM state codes and default timeout for mem_access_unit
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_B = 2'b00,
    MEM_SZ_H = 2'b01,
    MEM_SZ_W = 2'b10,
    MEM_SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    MAS_IDLE   = 2'b00,
    MAS_ACCESS = 2'b01,
    MAS_RESP   = 2'b10
  } mas_state_e;

  localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store replication, load extract/extend; misalign flag only with MEM_MISALIGN_CHK_EN
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  mem_size_e                   size,
  input  logic                        uns,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         be,
  output logic [DATA_W-1:0]           wdata_rep,
  output logic [DATA_W-1:0]           rdata_ext,
  output logic                        misalign
);

  localparam int NB = DATA_W / 8;

  mem_size_e   eff_size;
  logic [2:0]  mask;
  logic [2:0]  off3;
  logic [2:0]  aoff;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [63:0] rd64;
  logic [63:0] sh64;
  logic [63:0] rep64;
  logic [63:0] ext64;
  logic        sbit;

  // Work internally at 64 bits so both bus widths share one datapath; dword on a 32-bit bus acts as word.
  always_comb begin
    eff_size = size;
    if (DATA_W == 32 && size == MEM_SZ_D) eff_size = MEM_SZ_W;
    case (eff_size)
      MEM_SZ_B: mask = 3'd0;
      MEM_SZ_H: mask = 3'd1;
      MEM_SZ_W: mask = 3'd3;
      default:  mask = 3'd7;
    endcase
    off3 = 3'(off);
    aoff = off3 & ~mask;
`ifdef MEM_MISALIGN_CHK_EN
    misalign = (off3 & mask) != 3'd0;
`else
    misalign = 1'b0;
`endif
    wd64  = 64'(wdata);
    rd64  = 64'(rdata);
    sh64  = rd64 >> {aoff, 3'b000};
    be8   = 8'h00;
    rep64 = 64'd0;
    ext64 = 64'd0;
    sbit  = 1'b0;
    case (eff_size)
      MEM_SZ_B: begin
        be8   = 8'h01 << aoff;
        rep64 = {8{wd64[7:0]}};
        sbit  = sh64[7] & ~uns;
        ext64 = {{56{sbit}}, sh64[7:0]};
      end
      MEM_SZ_H: begin
        be8   = 8'h03 << aoff;
        rep64 = {4{wd64[15:0]}};
        sbit  = sh64[15] & ~uns;
        ext64 = {{48{sbit}}, sh64[15:0]};
      end
      MEM_SZ_W: begin
        be8   = 8'h0F << aoff;
        rep64 = {2{wd64[31:0]}};
        sbit  = sh64[31] & ~uns;
        ext64 = {{32{sbit}}, sh64[31:0]};
      end
      default: begin
        be8   = 8'hFF;
        rep64 = wd64;
        ext64 = sh64;
      end
    endcase
    be        = NB'(be8);
    wdata_rep = DATA_W'(rep64);
    rdata_ext = DATA_W'(ext64);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store unit with req/ack bus and core stall; MEM_MISALIGN_CHK_EN enables misaligned-access errors
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   Bus_addr,
  output logic                Bus_req,
  output logic                Bus_we,
  output logic [DATA_W/8-1:0] Bus_be,
  output logic [DATA_W-1:0]   Bus_wdata,
  input  logic                Bus_ack,
  input  logic [DATA_W-1:0]   Bus_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  mas_state_e        state;
  logic [7:0]        cnt;
  logic [OFF_W-1:0]  lat_off;
  mem_size_e         lat_size;
  logic              lat_uns;

  logic [OFF_W-1:0]  sel_off;
  mem_size_e         sel_size;
  logic              sel_uns;
  logic [NB-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_misalign;
  logic [ADDR_W-1:0] aligned_addr;

  // Lane logic sees the live request in IDLE and the latched request afterwards.
  always_comb begin
    sel_off      = (state == MAS_IDLE) ? req_addr[OFF_W-1:0] : lat_off;
    sel_size     = (state == MAS_IDLE) ? mem_size_e'(req_size) : lat_size;
    sel_uns      = (state == MAS_IDLE) ? req_unsigned : lat_uns;
    aligned_addr = req_addr & ~ADDR_W'(NB - 1);
    req_ready    = (state == MAS_IDLE);
    stall        = ((state == MAS_IDLE) & req_valid) | (state == MAS_ACCESS);
  end

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane (
    .off      (sel_off),
    .size     (sel_size),
    .uns      (sel_uns),
    .wdata    (req_wdata),
    .rdata    (Bus_rdata),
    .be       (lane_be),
    .wdata_rep(lane_wdata),
    .rdata_ext(lane_rdata),
    .misalign (lane_misalign)
  );

  // Request FSM: accept, drive the bus until ack or timeout, then present a one-cycle response.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= MAS_IDLE;
      cnt        <= 8'd0;
      lat_off    <= '0;
      lat_size   <= MEM_SZ_B;
      lat_uns    <= 1'b0;
      Bus_req    <= 1'b0;
      Bus_we     <= 1'b0;
      Bus_be     <= '0;
      Bus_addr   <= '0;
      Bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        MAS_IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            lat_off  <= req_addr[OFF_W-1:0];
            lat_size <= mem_size_e'(req_size);
            lat_uns  <= req_unsigned;
            cnt      <= 8'd0;
            if (lane_misalign) begin
              state      <= MAS_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= MAS_ACCESS;
              Bus_req   <= 1'b1;
              Bus_we    <= req_we;
              Bus_be    <= lane_be;
              Bus_addr  <= aligned_addr;
              Bus_wdata <= lane_wdata;
            end
          end
        end
        MAS_ACCESS: begin
          if (Bus_ack) begin
            state      <= MAS_RESP;
            Bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= Bus_we ? '0 : lane_rdata;
          end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
            state      <= MAS_RESP;
            Bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MAS_RESP: begin
          state      <= MAS_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: state <= MAS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (32-bit bus, timeout 4)
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          stall;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] Bus_addr;
  logic          Bus_req;
  logic          Bus_we;
  logic [3:0]    Bus_be;
  logic [DW-1:0] Bus_wdata;
  logic          Bus_ack;
  logic [DW-1:0] Bus_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  mem_access_unit #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .Bus_addr    (Bus_addr),
    .Bus_req     (Bus_req),
    .Bus_we      (Bus_we),
    .Bus_be      (Bus_be),
    .Bus_wdata   (Bus_wdata),
    .Bus_ack     (Bus_ack),
    .Bus_rdata   (Bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: pop one expected response whenever the DUT presents one.
  logic [31:0] mon_r;
  logic        mon_e;
  always @(negedge cpu_clk) begin
    if (!cpu_rst && resp_valid) begin
      if (exp_rdata_q.size() == 0) begin
        check("unexpected_resp", 64'(1), 64'(0));
      end else begin
        mon_r = exp_rdata_q.pop_front();
        mon_e = exp_err_q.pop_front();
        check("resp_rdata", 64'(resp_rdata), 64'(mon_r));
        check("resp_err", 64'(resp_err), 64'(mon_e));
      end
    end
  end

  // delay < 0 withholds the ack entirely.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int delay, input logic [31:0] exp_rd, input logic exp_err,
                       input logic bus, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    int n;
    @(negedge cpu_clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    exp_rdata_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    #1;
    check("stall_on_req", 64'(stall), 64'(1));
    check("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge cpu_clk);
    #1;
    req_valid = 1'b0;
    if (!bus) begin
      check("no_bus_req", 64'(Bus_req), 64'(0));
      check("misalign_resp_k1", 64'(resp_valid), 64'(1));
    end else begin
      check("bus_req_k1", 64'(Bus_req), 64'(1));
      check("bus_addr", 64'(Bus_addr), 64'(exp_addr));
      check("bus_be", 64'(Bus_be), 64'(exp_be));
      check("bus_we", 64'(Bus_we), 64'(we));
      check("bus_wdata", 64'(Bus_wdata), 64'(exp_wd));
      if (delay < 0) begin
        n = 0;
        while (Bus_req && n < 20) begin
          n++;
          @(posedge cpu_clk);
          #1;
        end
        check("timeout_req_cycles", 64'(n), 64'(TO));
        check("timeout_resp_valid", 64'(resp_valid), 64'(1));
        check("timeout_stall", 64'(stall), 64'(0));
      end else begin
        for (int c = 0; c < delay; c++) begin
          @(posedge cpu_clk);
          #1;
        end
        Bus_ack   = 1'b1;
        Bus_rdata = rdata;
        @(posedge cpu_clk);
        #1;
        Bus_ack   = 1'b0;
        Bus_rdata = 32'h0BAD_F00D;
        check("resp_latency", 64'(resp_valid), 64'(1));
        check("stall_in_resp", 64'(stall), 64'(0));
        check("bus_req_dropped", 64'(Bus_req), 64'(0));
      end
    end
    @(posedge cpu_clk);
    #1;
    check("resp_one_cycle", 64'(resp_valid), 64'(0));
    check("ready_after_resp", 64'(req_ready), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst      = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    Bus_ack      = 1'b0;
    Bus_rdata    = '0;
    @(negedge cpu_clk);
    check("rst_bus_req", 64'(Bus_req), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_bus_be", 64'(Bus_be), 64'(0));
    check("rst_bus_addr", 64'(Bus_addr), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_stall", 64'(stall), 64'(0));
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Word load, ack immediately.
    do_op(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h1004, 4'hF, 32'h0);
    // Signed and unsigned byte load at lane 3.
    do_op(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80123456, 0, 32'hFFFFFF80, 1'b0, 1'b1, 32'h1000, 4'b1000, 32'h0);
    do_op(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80123456, 1, 32'h00000080, 1'b0, 1'b1, 32'h1000, 4'b1000, 32'h0);
    // Half store, replicated data, store returns 0.
    do_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 2, 32'h0, 1'b0, 1'b1, 32'h2000, 4'b1100, 32'hABCDABCD);
    // Signed half load at upper lane.
    do_op(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 32'h80017FFF, 0, 32'hFFFF8001, 1'b0, 1'b1, 32'h1000, 4'b1100, 32'h0);
    // Byte store at offset 1.
    do_op(1'b1, 2'b00, 1'b1, 32'h0005, 32'h000000A5, 32'h0, 0, 32'h0, 1'b0, 1'b1, 32'h0004, 4'b0010, 32'hA5A5A5A5);
    // Dword code on a 32-bit bus behaves as word.
    do_op(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'hCAFEBABE, 0, 32'hCAFEBABE, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0);
    // Ack in the last allowed cycle beats the timeout.
    do_op(1'b0, 2'b10, 1'b1, 32'h3000, 32'h0, 32'h7654_3210, TO - 1, 32'h7654_3210, 1'b0, 1'b1, 32'h3000, 4'hF, 32'h0);
    // Ack withheld: timeout error.
    do_op(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h0, -1, 32'h0, 1'b1, 1'b1, 32'h3000, 4'hF, 32'h0);
    // Misaligned word load.
`ifdef MEM_MISALIGN_CHK_EN
    do_op(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h11223344, 0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
`else
    do_op(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h11223344, 0, 32'h11223344, 1'b0, 1'b1, 32'h1000, 4'hF, 32'h0);
`endif

    // Reset in the middle of an access.
    @(negedge cpu_clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h5000;
    @(posedge cpu_clk);
    #1;
    req_valid = 1'b0;
    check("mid_access_bus_req", 64'(Bus_req), 64'(1));
    #2;
    cpu_rst = 1'b1;
    #1;
    check("rst_drops_bus_req", 64'(Bus_req), 64'(0));
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check("ready_after_rst", 64'(req_ready), 64'(1));
    check("no_resp_after_rst", 64'(resp_valid), 64'(0));

    // Recovery after reset.
    do_op(1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 32'h0F0F0F0F, 0, 32'h0F0F0F0F, 1'b0, 1'b1, 32'h1008, 4'hF, 32'h0);

    repeat (5) @(posedge cpu_clk);
    #1;
    check("scoreboard_drained", 64'(exp_rdata_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
